// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash read controller.
package spi_flash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_XFER  = 3'd2,
        ST_RECV  = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
    localparam int         ADDR_BITS     = 24;
    localparam int         DATA_BITS     = 8;
    localparam int         DUMMY_BITS    = 8;

endpackage

// File: rtl/spi_clk_div.sv
// SCK half-period tick generator; sck toggles on ticks only while toggle_en is set.
module spi_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic toggle_en,
    output logic tick,
    output logic sck
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] div_cnt;

    assign tick = en && (div_cnt == DIV_LAST);

    // Disabling clears the phase so every transaction starts from a full half-period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= 8'd0;
            sck     <= 1'b0;
        end else if (!en) begin
            div_cnt <= 8'd0;
            sck     <= 1'b0;
        end else begin
            div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
            if (tick && toggle_en) begin
                sck <= ~sck;
            end
        end
    end

endmodule

// File: rtl/spi_flash_reader.sv
// Single-byte SPI flash reader (mode 0). Define SPI_FAST_READ_EN to use the
// 0x0B fast-read command with 8 dummy bits instead of the 0x03 read command.
//
// state | meaning
// IDLE  | cs_n high, waiting for a trigger rising edge
// START | cs_n low, command MSB on mosi, one half-period of setup
// XFER  | shifting command, address (and dummy bits) out MSB-first
// RECV  | sampling 8 data bits from miso on sck rising edges
// STOP  | cs_n high for one half-period before returning to IDLE
import spi_flash_pkg::*;

module spi_flash_reader #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] spi_addr,
    input  logic        spi_trigger,
    output logic [7:0]  spi_data_out,
    output logic        spi_busy,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

`ifdef SPI_FAST_READ_EN
    localparam int XFER_BITS = 8 + ADDR_BITS + DUMMY_BITS;
`else
    localparam int XFER_BITS = 8 + ADDR_BITS;
`endif
    localparam logic [5:0] XFER_LAST = 6'(XFER_BITS - 1);
    localparam logic [5:0] RECV_LAST = 6'(DATA_BITS - 1);

    state_t                 state;
    logic                   trig_q;
    logic [5:0]             bit_cnt;
    logic [XFER_BITS-1:0]   tx_sr;
    logic [DATA_BITS-1:0]   rx_sr;
    logic                   tick;
    logic                   start;
    logic                   clk_en;
    logic                   toggle_en;

    assign start     = spi_trigger && !trig_q;
    assign clk_en    = (state != ST_IDLE);
    assign toggle_en = (state == ST_XFER) || (state == ST_RECV);

    // Zeros shift in behind the command, so mosi is 0 once XFER completes.
    assign spi_mosi  = tx_sr[XFER_BITS-1];

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (clk_en),
        .toggle_en (toggle_en),
        .tick      (tick),
        .sck       (spi_sck)
    );

    // trig_q resets high so a trigger already high at reset release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            trig_q       <= 1'b1;
            bit_cnt      <= 6'd0;
            tx_sr        <= '0;
            rx_sr        <= '0;
            spi_busy     <= 1'b0;
            spi_cs_n     <= 1'b1;
            spi_data_out <= 8'h00;
        end else begin
            trig_q <= spi_trigger;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_START;
                        spi_busy <= 1'b1;
                        spi_cs_n <= 1'b0;
                        bit_cnt  <= 6'd0;
`ifdef SPI_FAST_READ_EN
                        tx_sr    <= {CMD_FAST_READ, spi_addr, {DUMMY_BITS{1'b0}}};
`else
                        tx_sr    <= {CMD_READ, spi_addr};
`endif
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (tick && spi_sck) begin
                        tx_sr <= tx_sr << 1;
                        if (bit_cnt == XFER_LAST) begin
                            state   <= ST_RECV;
                            bit_cnt <= 6'd0;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                end
                ST_RECV: begin
                    if (tick && !spi_sck) begin
                        rx_sr <= {rx_sr[DATA_BITS-2:0], spi_miso};
                    end else if (tick && spi_sck) begin
                        if (bit_cnt == RECV_LAST) begin
                            state        <= ST_STOP;
                            spi_cs_n     <= 1'b1;
                            spi_data_out <= rx_sr;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        state    <= ST_IDLE;
                        spi_busy <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader: default divider instance plus a CLK_DIV=1 instance.
module tb_spi_flash_reader;

`ifdef SPI_FAST_READ_EN
    localparam int XB    = 40;
    localparam int BUSY0 = 196;
    localparam int BUSY1 = 98;
`else
    localparam int XB    = 32;
    localparam int BUSY0 = 164;
    localparam int BUSY1 = 82;
`endif

    logic        clk;
    logic        rst_n;
    logic [23:0] addr0, addr1;
    logic        trig0, trig1;
    logic [7:0]  data0, data1;
    logic        busy0, busy1, cs0, cs1, sck0, sck1, mosi0, mosi1;
    logic        miso0 = 1'b0;
    logic        miso1 = 1'b0;

    int errors = 0;
    int checks = 0;

    spi_flash_reader dut0 (
        .clk(clk), .rst_n(rst_n), .spi_addr(addr0), .spi_trigger(trig0),
        .spi_data_out(data0), .spi_busy(busy0), .spi_cs_n(cs0),
        .spi_sck(sck0), .spi_mosi(mosi0), .spi_miso(miso0)
    );

    spi_flash_reader #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .spi_addr(addr1), .spi_trigger(trig1),
        .spi_data_out(data1), .spi_busy(busy1), .spi_cs_n(cs1),
        .spi_sck(sck1), .spi_mosi(mosi1), .spi_miso(miso1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [39:0] exp_stream(input logic [23:0] a);
`ifdef SPI_FAST_READ_EN
        return {8'h0B, a, 8'h00};
`else
        return {8'h00, 8'h03, a};
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Flash models and monitors, sampled on the falling clk edge.
    logic [39:0] got0 = '0, got1 = '0;
    logic [7:0]  mb0 = 8'h00, mb1 = 8'h00;
    logic        sck0_p = 0, cs0_p = 1, busy0_p = 0, mosi0_p = 0;
    logic        sck1_p = 0, cs1_p = 1, busy1_p = 0;
    int nr0 = 0, csf0 = 0, blen0 = 0, bcnt0 = 0, glitch0 = 0;
    int nr1 = 0, csf1 = 0, blen1 = 0, bcnt1 = 0, gap1 = 0, badp1 = 0;

    always @(negedge clk) begin
        if (cs0_p && !cs0) begin nr0 = 0; got0 = '0; csf0++; end
        if (!cs0 && sck0_p && sck0 && (mosi0 !== mosi0_p)) glitch0++;
        if (!cs0 && !sck0_p && sck0) begin
            if (nr0 < XB) got0 = {got0[38:0], mosi0};
            nr0++;
        end
        if (!cs0 && sck0_p && !sck0 && nr0 >= XB && nr0 < XB + 8) miso0 = mb0[7 - (nr0 - XB)];
        if (busy0) bcnt0++;
        else if (busy0_p) begin blen0 = bcnt0; bcnt0 = 0; end
        sck0_p = sck0; cs0_p = cs0; busy0_p = busy0; mosi0_p = mosi0;
    end

    always @(negedge clk) begin
        if (cs1_p && !cs1) begin nr1 = 0; got1 = '0; csf1++; gap1 = 0; end
        gap1++;
        if (!cs1 && !sck1_p && sck1) begin
            if (nr1 > 0 && gap1 != 2) badp1++;
            gap1 = 0;
            if (nr1 < XB) got1 = {got1[38:0], mosi1};
            nr1++;
        end
        if (!cs1 && sck1_p && !sck1 && nr1 >= XB && nr1 < XB + 8) miso1 = mb1[7 - (nr1 - XB)];
        if (busy1) bcnt1++;
        else if (busy1_p) begin blen1 = bcnt1; bcnt1 = 0; end
        sck1_p = sck1; cs1_p = cs1; busy1_p = busy1;
    end

    task automatic wait_idle0();
        int n = 0;
        while (busy0 && n < 1000) begin @(negedge clk); n++; end
        chk("busy0_timeout", busy0, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic run0(input logic [23:0] a, input logic [7:0] b);
        mb0 = b;
        @(negedge clk); trig0 = 1'b0; addr0 = a;
        @(negedge clk); trig0 = 1'b1;
        @(negedge clk);
        chk("busy_rise", busy0, 1'b1);
        chk("cs_fall", cs0, 1'b0);
        chk("sck_idle_start", sck0, 1'b0);
        wait_idle0();
        trig0 = 1'b0;
    endtask

    typedef struct {
        logic [23:0] a;
        logic [7:0]  b;
    } vec_t;

    vec_t vecs[5];
    int   csf_before;
    int   n;

    initial begin
        vecs[0] = '{24'h012345, 8'hA5};
        vecs[1] = '{24'h000010, 8'h7E};
        vecs[2] = '{24'h000000, 8'hFF};
        vecs[3] = '{24'hFFFFFF, 8'h00};
        vecs[4] = '{24'h800001, 8'h81};

        rst_n = 1'b1; trig0 = 1'b0; trig1 = 1'b0; addr0 = '0; addr1 = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", busy0, 1'b0);
        chk("rst_cs_n", cs0, 1'b1);
        chk("rst_sck", sck0, 1'b0);
        chk("rst_mosi", mosi0, 1'b0);
        chk("rst_data", data0, 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset during bit 20 of the command/address phase.
        mb0 = 8'h5A; addr0 = 24'h345678;
        trig0 = 1'b1;
        n = 0;
        while (nr0 < 20 && n < 1000) begin @(negedge clk); n++; end
        chk("abort_reach_bit20", nr0 >= 20, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_cs_n", cs0, 1'b1);
        chk("abort_sck", sck0, 1'b0);
        chk("abort_busy", busy0, 1'b0);
        chk("abort_data", data0, 8'h00);
        @(negedge clk); rst_n = 1'b1; trig0 = 1'b0;
        repeat (2) @(negedge clk);
        run0(24'h0ABCDE, 8'hC3);
        chk("after_abort_data", data0, 8'hC3);
        chk("after_abort_stream", got0, exp_stream(24'h0ABCDE));

        for (int i = 0; i < 5; i++) begin
            run0(vecs[i].a, vecs[i].b);
            chk("vec_stream", got0, exp_stream(vecs[i].a));
            chk("vec_data", data0, vecs[i].b);
            chk("vec_busy_len", blen0, BUSY0);
            chk("vec_cs_idle", cs0, 1'b1);
        end
        chk("mosi_stable_sck_high", glitch0, 0);

        // Extra trigger pulse during a read is dropped.
        csf_before = csf0;
        mb0 = 8'h96;
        @(negedge clk); trig0 = 1'b0; addr0 = 24'h112233;
        @(negedge clk); trig0 = 1'b1;
        repeat (30) @(negedge clk); trig0 = 1'b0;
        repeat (2) @(negedge clk); trig0 = 1'b1;
        repeat (2) @(negedge clk); trig0 = 1'b0;
        wait_idle0();
        repeat (300) @(negedge clk);
        chk("ignore_cs_falls", csf0 - csf_before, 1);
        chk("ignore_data", data0, 8'h96);
        chk("ignore_idle", busy0, 1'b0);

        // Trigger held high across reset release starts nothing.
        @(negedge clk); rst_n = 1'b0; trig0 = 1'b1;
        repeat (2) @(negedge clk); rst_n = 1'b1;
        csf_before = csf0;
        repeat (300) @(negedge clk);
        chk("held_no_xfer", csf0 - csf_before, 0);
        chk("held_busy", busy0, 1'b0);
        chk("held_data_reset", data0, 8'h00);
        run0(24'h00BEEF, 8'h3F);
        chk("held_then_edge", csf0 - csf_before, 1);
        chk("held_then_data", data0, 8'h3F);

        // CLK_DIV=1 instance.
        mb1 = 8'h3C;
        @(negedge clk); trig1 = 1'b0; addr1 = 24'hFFFFFF;
        @(negedge clk); trig1 = 1'b1;
        n = 0;
        @(negedge clk);
        while (busy1 && n < 1000) begin @(negedge clk); n++; end
        chk("div1_timeout", busy1, 1'b0);
        repeat (3) @(negedge clk);
        trig1 = 1'b0;
        chk("div1_data", data1, 8'h3C);
        chk("div1_busy_len", blen1, BUSY1);
        chk("div1_stream", got1, exp_stream(24'hFFFFFF));
        chk("div1_sck_period", badp1, 0);
        chk("div1_sck_rises", nr1, XB + 8);
        chk("div1_cs_falls", csf1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
